mchan_demux_ipa: RTL and testbench

MCHAN_DEMUX_IPA -- requirements
Module: mchan_demux_ipa

---
 rtl/mchan_demux_ipa_if.sv | 30 +++
 rtl/mchan_demux_ipa.sv | 101 ++++++++++
 tb/tb_mchan_demux_ipa.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mchan_demux_ipa_if.sv
// Bus bundle for the multi-channel demultiplexer: one upstream request/grant
// channel fanning out to N_MASTER downstream request/grant channels.
interface mchan_demux_ipa_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_MASTER   = 2,
    parameter int ID_WIDTH   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) ();

    logic                                req_i;
    logic                                gnt_o;
    logic [DATA_WIDTH-1:0]               data_i;
    logic [ID_WIDTH-1:0]                 id_i;
    logic [N_MASTER-1:0]                 req_o;
    logic [N_MASTER-1:0]                 gnt_i;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_o;
    logic                                err_o;

    // Demultiplexer side
    modport slave (
        input  req_i, data_i, id_i, gnt_i,
        output gnt_o, req_o, data_o, err_o
    );

    // Environment side: drives upstream traffic and downstream grants
    modport master (
        output req_i, data_i, id_i, gnt_i,
        input  gnt_o, req_o, data_o, err_o
    );

endinterface

// File: rtl/mchan_demux_ipa.sv
// Multi-channel demultiplexer: routes each upstream word to the FIFO of the
// port selected by id_i. Every port has its own small FIFO so that a stalled
// port only blocks traffic addressed to it. The upstream grant is derived
// from FIFO fullness alone, never from the downstream grants.
module mchan_demux_ipa #(
    parameter int DATA_WIDTH = 32,
    parameter int N_MASTER   = 2,
    parameter int ID_WIDTH   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mchan_demux_ipa_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem    [N_MASTER][FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr [N_MASTER];
    logic [PTR_W-1:0]      wr_ptr [N_MASTER];
    logic [CNT_W-1:0]      count  [N_MASTER];

    logic [N_MASTER-1:0]   full;
    logic [N_MASTER-1:0]   pop;
    logic [N_MASTER-1:0]   push;
    logic                  bad_xfer;
    logic                  err;
    logic [ID_WIDTH-1:0]   id;

    assign id = bus.id_i;

    // Per-port status and downstream outputs; data_o shows the stored head entry
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            full[m]       = (count[m] == CNT_W'(FIFO_DEPTH));
            pop[m]        = (count[m] != '0) && bus.gnt_i[m];
            bus.req_o[m]  = (count[m] != '0);
            bus.data_o[m] = mem[m][rd_ptr[m]];
        end
    end

    // Upstream grant and push decode; a single port ignores id_i entirely
    always_comb begin
        bus.gnt_o = 1'b1;
        push      = '0;
        bad_xfer  = bus.req_i && (N_MASTER > 1) && (int'(id) >= N_MASTER);
        for (int m = 0; m < N_MASTER; m++) begin
            if ((N_MASTER == 1) || (int'(id) == m)) begin
                bus.gnt_o = !full[m];
                push[m]   = bus.req_i && !full[m];
            end
        end
    end

    // Pointer and occupancy bookkeeping for every port FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < N_MASTER; m++) begin
                rd_ptr[m] <= '0;
                wr_ptr[m] <= '0;
                count[m]  <= '0;
            end
        end else begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (push[m]) begin
                    wr_ptr[m] <= wr_ptr[m] + PTR_W'(1);
                end
                if (pop[m]) begin
                    rd_ptr[m] <= rd_ptr[m] + PTR_W'(1);
                end
                case ({push[m], pop[m]})
                    2'b10:   count[m] <= count[m] + CNT_W'(1);
                    2'b01:   count[m] <= count[m] - CNT_W'(1);
                    default: count[m] <= count[m];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk) begin
        for (int m = 0; m < N_MASTER; m++) begin
            if (push[m]) begin
                mem[m][wr_ptr[m]] <= bus.data_i;
            end
        end
    end

    // Sticky error for accepted transfers addressed to a non-existent port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bad_xfer) begin
            err <= 1'b1;
        end
    end

    assign bus.err_o = err;

endmodule

// File: tb/tb_mchan_demux_ipa.sv
// Self-checking bench for mchan_demux_ipa with three ports and two-entry
// FIFOs. A queue-per-port model predicts every output; directed sequences
// pin the model with literal expectations before a randomized run.
module tb_mchan_demux_ipa;

    localparam int DW = 8;
    localparam int NM = 3;
    localparam int IW = 2;
    localparam int FD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mchan_demux_ipa_if #(.DATA_WIDTH(DW), .N_MASTER(NM), .ID_WIDTH(IW)) bus ();

    mchan_demux_ipa #(
        .DATA_WIDTH(DW),
        .N_MASTER  (NM),
        .ID_WIDTH  (IW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q [NM][$];
    bit            err_m;
    bit            stream_mode = 1'b0;
    int            rx_count    = 0;

    // Generic comparison with failure reporting
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant the model predicts for a given id
    function automatic bit model_gnt(input logic [IW-1:0] id);
        int idx;
        idx = int'(id);
        if (idx >= NM) return 1'b1;
        return q[idx].size() < FD;
    endfunction

    // Behavioural model: pops and pushes are queue operations on each edge
    always @(posedge clk or negedge rst_n) begin : model_update
        int idx;
        bit g;
        if (!rst_n) begin
            for (int m = 0; m < NM; m++) q[m].delete();
            err_m = 1'b0;
        end else begin
            g   = model_gnt(bus.id_i);
            idx = int'(bus.id_i);
            for (int m = 0; m < NM; m++) begin
                if (q[m].size() > 0 && bus.gnt_i[m]) void'(q[m].pop_front());
            end
            if (bus.req_i && g) begin
                if (idx < NM) q[idx].push_back(bus.data_i);
                else          err_m = 1'b1;
            end
        end
    end

    // Compare every DUT output against the model
    task automatic checkOutput();
        for (int m = 0; m < NM; m++) begin
            check($sformatf("req_o[%0d]", m), 32'(bus.req_o[m]), 32'(q[m].size() != 0));
            if (q[m].size() != 0)
                check($sformatf("data_o[%0d]", m), 32'(bus.data_o[m]), 32'(q[m][0]));
        end
        check("gnt_o", 32'(bus.gnt_o), 32'(model_gnt(bus.id_i)));
        check("err_o", 32'(bus.err_o), 32'(err_m));
    endtask

    // Per-cycle compare process, plus in-order tracking of the port 2 stream
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput();
            if (stream_mode && bus.req_o[2] && bus.gnt_i[2]) begin
                check("stream_order", 32'(bus.data_o[2]), 32'(rx_count));
                rx_count++;
            end
        end
    end

    // Drive a new input set just after the next rising edge
    task automatic applyStimulus(input logic req, input logic [IW-1:0] id,
                                 input logic [DW-1:0] data, input logic [NM-1:0] g);
        @(posedge clk);
        #1;
        bus.req_i  = req;
        bus.id_i   = id;
        bus.data_i = data;
        bus.gnt_i  = g;
    endtask

    initial begin
        int next;
        int cyc;
        bus.req_i  = 1'b0;
        bus.id_i   = '0;
        bus.data_i = '0;
        bus.gnt_i  = '0;

        // Reset state
        #12;
        check("reset_req_o", 32'(bus.req_o), 32'h0);
        check("reset_gnt_o", 32'(bus.gnt_o), 32'h1);
        check("reset_err_o", 32'(bus.err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push to port 1 with no downstream grant
        applyStimulus(1'b1, 2'd1, 8'hA5, 3'b000);
        #1 check("push_grant", 32'(bus.gnt_o), 32'h1);
        applyStimulus(1'b0, 2'd1, 8'h00, 3'b000);
        #1;
        check("single_req_o", 32'(bus.req_o), 32'h2);
        check("single_data_o1", 32'(bus.data_o[1]), 32'hA5);
        check("single_gnt_o", 32'(bus.gnt_o), 32'h1);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);

        // Fill port 0; third word is blocked while port 1 still accepts
        applyStimulus(1'b1, 2'd0, 8'h10, 3'b000);
        applyStimulus(1'b1, 2'd0, 8'h11, 3'b000);
        applyStimulus(1'b1, 2'd0, 8'h12, 3'b000);
        @(negedge clk);
        #1;
        check("full_port_block", 32'(bus.gnt_o), 32'h0);
        bus.id_i = 2'd1;
        #1 check("other_port_grant", 32'(bus.gnt_o), 32'h1);

        // Pop on a full port does not pass through to the upstream grant
        applyStimulus(1'b1, 2'd0, 8'h13, 3'b001);
        #1 check("no_pop_passthrough", 32'(bus.gnt_o), 32'h0);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);
        #1;
        check("regrant_after_pop", 32'(bus.gnt_o), 32'h1);
        check("head_after_pop", 32'(bus.data_o[0]), 32'h11);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);

        // Out-of-range id: granted, dropped, sticky error
        applyStimulus(1'b1, 2'd3, 8'h55, 3'b000);
        #1 check("bad_id_grant", 32'(bus.gnt_o), 32'h1);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);
        #1;
        check("bad_id_err", 32'(bus.err_o), 32'h1);
        check("bad_id_req_o", 32'(bus.req_o), 32'h0);
        repeat (3) applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);
        #1 check("err_sticky", 32'(bus.err_o), 32'h1);

        // Asynchronous reset between edges discards buffered words
        applyStimulus(1'b1, 2'd1, 8'h21, 3'b000);
        applyStimulus(1'b1, 2'd1, 8'h22, 3'b000);
        applyStimulus(1'b0, 2'd1, 8'h00, 3'b000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_req_o", 32'(bus.req_o), 32'h0);
        check("async_reset_err_o", 32'(bus.err_o), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 2'd1, 8'h33, 3'b000);
        applyStimulus(1'b0, 2'd1, 8'h00, 3'b000);
        #1;
        check("post_reset_req_o", 32'(bus.req_o), 32'h2);
        check("post_reset_data_o1", 32'(bus.data_o[1]), 32'h33);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);

        // Stream 0..9 into port 2 with a random downstream grant
        stream_mode = 1'b1;
        next = 0;
        cyc  = 0;
        while (cyc < 200 && rx_count < 10) begin
            @(posedge clk);
            #1;
            bus.gnt_i = {1'($urandom_range(0, 1)), 2'b00};
            if (next < 10) begin
                bus.req_i  = 1'b1;
                bus.id_i   = 2'd2;
                bus.data_i = DW'(next);
                if (model_gnt(2'd2)) next++;
            end else begin
                bus.req_i = 1'b0;
            end
            cyc++;
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);
        stream_mode = 1'b0;
        check("stream_complete", 32'(rx_count), 32'd10);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);

        // Randomized traffic, including out-of-range ids and idle grants
        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)), IW'($urandom_range(0, 3)),
                          DW'($urandom), NM'($urandom));
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b000);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
